reg_access_arbiter: RTL and testbench

//  Shares one regstr register instance between N_REQ requesters.

---
 rtl/reg_arb_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/reg_access_arbiter.sv | 144 ++++++++++++++
 tb/tb_reg_access_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/reg_arb_pkg.sv
// Shared types for the register access arbiter: requester op codes and FSM states.
package reg_arb_pkg;

   typedef enum logic [1:0] {
      OP_READ  = 2'b00,
      OP_WRITE = 2'b01,
      OP_INC   = 2'b10,
      OP_CLEAR = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ISSUE = 2'b01,
      RESP  = 2'b10
   } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first eligible requester at or above the
// pointer, wrapping around. The pointer itself is stored by the parent.
//  eligible_i   : per-requester eligibility
//  rr_ptr_i     : current round-robin start index
//  grant_idx_c  : index of the selected requester (0 when none)
//  any_grant_c  : high when some requester is eligible
module rr_arbiter #(
   parameter int unsigned N_REQ = 4,
   localparam int unsigned IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] eligible_i,
   input  logic [IDX_W-1:0] rr_ptr_i,
   output logic [IDX_W-1:0] grant_idx_c,
   output logic             any_grant_c
);

   // Scan N_REQ positions starting at the pointer; keep the first hit.
   always_comb begin
      grant_idx_c = '0;
      any_grant_c = 1'b0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         int unsigned idx;
         idx = 32'(rr_ptr_i) + k;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (!any_grant_c && eligible_i[IDX_W'(idx)]) begin
            any_grant_c = 1'b1;
            grant_idx_c = IDX_W'(idx);
         end
      end
   end

endmodule

// File: rtl/reg_access_arbiter.sv
// Shares one regstr register between N_REQ requesters. A round-robin grant
// selects one op, the FSM pulses the matching regstr control for one cycle,
// then returns the post-op register value with a one-cycle ack.
//  clk, rst_s        : clock, synchronous active-high reset
//  req, op, wdata    : per-requester request, op code and write data
//  ack, rdata        : one-hot completion pulse and post-op register value
//  busy              : high while an op is in flight
//  reg_we/inc/clr    : regstr controls, at most one high, one cycle per op
//  reg_din, reg_dout : regstr data in / data out
module reg_access_arbiter
   import reg_arb_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned N_REQ = 4
) (
   input  logic                   clk,
   input  logic                   rst_s,
   input  logic [N_REQ-1:0]       req,
   input  logic [2*N_REQ-1:0]     op,
   input  logic [WIDTH*N_REQ-1:0] wdata,
   output logic [N_REQ-1:0]       ack,
   output logic [WIDTH-1:0]       rdata,
   output logic                   busy,
   output logic                   reg_we,
   output logic                   reg_inc,
   output logic                   reg_clr,
   output logic [WIDTH-1:0]       reg_din,
   input  logic [WIDTH-1:0]       reg_dout
);

   localparam int unsigned IDX_W = $clog2(N_REQ);

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]   grant_q, grant_d;
   logic [N_REQ-1:0]   ack_q, ack_d;
   logic [WIDTH-1:0]   rdata_q, rdata_d;
   logic               busy_q, busy_d;
   logic               we_q, we_d;
   logic               inc_q, inc_d;
   logic               clr_q, clr_d;
   logic [WIDTH-1:0]   din_q, din_d;

   logic [N_REQ-1:0]   eligible;
   logic [IDX_W-1:0]   grant_idx_c;
   logic               any_grant_c;
   op_t                op_sel;
   logic [WIDTH-1:0]   wdata_sel;

   // A requester still holding req during its own ack cycle is not re-granted.
   assign eligible = req & ~ack_q;

   rr_arbiter #(.N_REQ(N_REQ)) u_rr (
      .eligible_i  (eligible),
      .rr_ptr_i    (rr_ptr_q),
      .grant_idx_c (grant_idx_c),
      .any_grant_c (any_grant_c)
   );

   // Capture mux for the winning requester's op and data.
   assign op_sel    = op_t'(op[{grant_idx_c, 1'b0} +: 2]);
   assign wdata_sel = wdata[32'(grant_idx_c) * WIDTH +: WIDTH];

   // Next-state and registered-output logic.
   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      grant_d  = grant_q;
      ack_d    = '0;
      rdata_d  = rdata_q;
      busy_d   = 1'b0;
      we_d     = 1'b0;
      inc_d    = 1'b0;
      clr_d    = 1'b0;
      din_d    = din_q;

      case (state_q)
         IDLE: begin
            if (any_grant_c) begin
               grant_d = grant_idx_c;
               busy_d  = 1'b1;
               state_d = ISSUE;
               case (op_sel)
                  OP_READ:  ;
                  OP_WRITE: begin
                     we_d  = 1'b1;
                     din_d = wdata_sel;
                  end
                  OP_INC:   inc_d = 1'b1;
                  OP_CLEAR: clr_d = 1'b1;
               endcase
            end
         end
         ISSUE: begin
            // regstr applies the control on the edge that leaves this state.
            busy_d  = 1'b1;
            state_d = RESP;
         end
         RESP: begin
            rdata_d         = reg_dout;
            ack_d[grant_q]  = 1'b1;
            rr_ptr_d        = (32'(grant_q) == N_REQ - 1) ? '0 : grant_q + IDX_W'(1);
            state_d         = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst_s) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         grant_q  <= '0;
         ack_q    <= '0;
         rdata_q  <= '0;
         busy_q   <= 1'b0;
         we_q     <= 1'b0;
         inc_q    <= 1'b0;
         clr_q    <= 1'b0;
         din_q    <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         grant_q  <= grant_d;
         ack_q    <= ack_d;
         rdata_q  <= rdata_d;
         busy_q   <= busy_d;
         we_q     <= we_d;
         inc_q    <= inc_d;
         clr_q    <= clr_d;
         din_q    <= din_d;
      end
   end

   assign ack     = ack_q;
   assign rdata   = rdata_q;
   assign busy    = busy_q;
   assign reg_we  = we_q;
   assign reg_inc = inc_q;
   assign reg_clr = clr_q;
   assign reg_din = din_q;

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Bench for reg_access_arbiter driving a behavioural regstr register.
module tb_reg_access_arbiter;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned N_REQ = 4;

   logic                   clk;
   logic                   rst_s;
   logic [N_REQ-1:0]       req;
   logic [2*N_REQ-1:0]     op;
   logic [WIDTH*N_REQ-1:0] wdata;
   logic [N_REQ-1:0]       ack;
   logic [WIDTH-1:0]       rdata;
   logic                   busy;
   logic                   reg_we;
   logic                   reg_inc;
   logic                   reg_clr;
   logic [WIDTH-1:0]       reg_din;
   logic [WIDTH-1:0]       reg_dout;

   logic                   reg_init;
   logic [WIDTH-1:0]       reg_val;

   int n_tests;
   int n_fail;

   reg_access_arbiter #(.WIDTH(WIDTH), .N_REQ(N_REQ)) dut (
      .clk      (clk),
      .rst_s    (rst_s),
      .req      (req),
      .op       (op),
      .wdata    (wdata),
      .ack      (ack),
      .rdata    (rdata),
      .busy     (busy),
      .reg_we   (reg_we),
      .reg_inc  (reg_inc),
      .reg_clr  (reg_clr),
      .reg_din  (reg_din),
      .reg_dout (reg_dout)
   );

   // Behavioural regstr: clear has priority, then write, then increment.
   always_ff @(posedge clk) begin
      if (reg_init || reg_clr)  reg_val <= '0;
      else if (reg_we)          reg_val <= reg_din;
      else if (reg_inc)         reg_val <= reg_val + 32'd1;
   end
   assign reg_dout = reg_val;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      int unsigned      idx;
      logic [1:0]       op;
      logic [WIDTH-1:0] wdata;
      logic [WIDTH-1:0] exp_rdata;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [2:0] ctl_for(input logic [1:0] o);
      case (o)
         2'b01:   return 3'b100;
         2'b10:   return 3'b010;
         2'b11:   return 3'b001;
         default: return 3'b000;
      endcase
   endfunction

   task automatic set_req(input int unsigned i, input logic [1:0] o, input logic [WIDTH-1:0] d);
      req[i]             = 1'b1;
      op[2*i +: 2]       = o;
      wdata[WIDTH*i +: WIDTH] = d;
   endtask

   // One isolated op with cycle-exact checks of controls, ack and rdata.
   task automatic run_txn(input vec_t v);
      logic [N_REQ-1:0] exp_ack;
      exp_ack = '0;
      exp_ack[v.idx] = 1'b1;
      set_req(v.idx, v.op, v.wdata);
      tick();
      chk("issue_ctl",  64'({reg_we, reg_inc, reg_clr}), 64'(ctl_for(v.op)));
      chk("issue_busy", 64'(busy), 64'd1);
      chk("issue_ack",  64'(ack), 64'd0);
      if (v.op == 2'b01) chk("issue_din", 64'(reg_din), 64'(v.wdata));
      tick();
      chk("resp_ctl",   64'({reg_we, reg_inc, reg_clr}), 64'd0);
      chk("resp_ack",   64'(ack), 64'd0);
      tick();
      chk("ack_onehot", 64'(ack), 64'(exp_ack));
      chk("ack_rdata",  64'(rdata), 64'(v.exp_rdata));
      req[v.idx] = 1'b0;
      tick();
      chk("ack_clear",  64'(ack), 64'd0);
      chk("rdata_hold", 64'(rdata), 64'(v.exp_rdata));
   endtask

   // Poll for the next ack within a cycle budget; checks value, data and latency.
   task automatic wait_ack(input string name, input logic [N_REQ-1:0] exp_ack,
                           input logic [WIDTH-1:0] exp_rdata, input int exp_cycles);
      int cyc;
      cyc = 0;
      do begin
         tick();
         cyc++;
      end while (ack == '0 && cyc < 10);
      chk({name, "_ack"},     64'(ack), 64'(exp_ack));
      chk({name, "_rdata"},   64'(rdata), 64'(exp_rdata));
      chk({name, "_latency"}, 64'(cyc), 64'(exp_cycles));
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;

      vecs[0] = '{0, 2'b01, 32'h0000_00A5, 32'h0000_00A5};
      vecs[1] = '{1, 2'b00, 32'h0,         32'h0000_00A5};
      vecs[2] = '{2, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      vecs[3] = '{3, 2'b10, 32'h0,         32'h0000_0000};
      vecs[4] = '{0, 2'b00, 32'h0,         32'h0000_0000};
      vecs[5] = '{1, 2'b10, 32'h0,         32'h0000_0001};
      vecs[6] = '{2, 2'b01, 32'h0000_1234, 32'h0000_1234};
      vecs[7] = '{3, 2'b11, 32'h0,         32'h0000_0000};

      // Reset with every requester asking for a READ.
      rst_s    = 1'b1;
      reg_init = 1'b1;
      req      = '1;
      op       = '0;
      wdata    = '0;
      tick();
      tick();
      chk("rst_ack",   64'(ack), 64'd0);
      chk("rst_rdata", 64'(rdata), 64'd0);
      chk("rst_busy",  64'(busy), 64'd0);
      chk("rst_ctl",   64'({reg_we, reg_inc, reg_clr}), 64'd0);
      chk("rst_din",   64'(reg_din), 64'd0);
      rst_s    = 1'b0;
      reg_init = 1'b0;
      wait_ack("first_grant", 4'b0001, 32'h0, 3);
      req = '0;
      tick();

      // Directed single ops, including INC wrap and control-free READ.
      foreach (vecs[i]) run_txn(vecs[i]);

      // Fairness: all four held, INC from 0; pointer is 0 after the CLEAR by req3.
      for (int i = 0; i < N_REQ; i++) set_req(i, 2'b10, 32'h0);
      wait_ack("rr0", 4'b0001, 32'd1, 3);
      wait_ack("rr1", 4'b0010, 32'd2, 3);
      wait_ack("rr2", 4'b0100, 32'd3, 3);
      wait_ack("rr3", 4'b1000, 32'd4, 3);
      wait_ack("rr4", 4'b0001, 32'd5, 3);
      req = '0;
      tick();
      tick();
      chk("rr_idle_ack", 64'(ack), 64'd0);

      // Ack-cycle mask: req1 held through its ack while req2 waits.
      set_req(1, 2'b10, 32'h0);
      set_req(2, 2'b10, 32'h0);
      wait_ack("mask_a", 4'b0010, 32'd6, 3);
      wait_ack("mask_b", 4'b0100, 32'd7, 3);
      req[2] = 1'b0;
      wait_ack("mask_c", 4'b0010, 32'd8, 3);
      tick();
      chk("mask_no_regrant_inc",  64'(reg_inc), 64'd0);
      chk("mask_no_regrant_busy", 64'(busy), 64'd0);
      tick();
      chk("mask_regrant_inc", 64'(reg_inc), 64'd1);
      req[1] = 1'b0;
      tick();
      tick();
      chk("mask_regrant_ack",   64'(ack), 64'b0010);
      chk("mask_regrant_rdata", 64'(rdata), 64'd9);
      tick();

      // Reset during ISSUE of a WRITE: op aborted, register update stands.
      set_req(2, 2'b01, 32'h55);
      tick();
      chk("abort_we", 64'(reg_we), 64'd1);
      rst_s = 1'b1;
      req   = '0;
      tick();
      chk("abort_rst_busy",  64'(busy), 64'd0);
      chk("abort_rst_we",    64'(reg_we), 64'd0);
      chk("abort_rst_rdata", 64'(rdata), 64'd0);
      rst_s = 1'b0;
      begin
         logic seen;
         seen = 1'b0;
         for (int c = 0; c < 4; c++) begin
            tick();
            if (ack != '0) seen = 1'b1;
         end
         chk("abort_no_ack", 64'(seen), 64'd0);
      end
      set_req(1, 2'b00, 32'h0);
      set_req(3, 2'b00, 32'h0);
      wait_ack("abort_next", 4'b0010, 32'h55, 3);
      req = '0;
      tick();
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
